// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-master arbiter and sequencer for the single-port data memory.
// Master 0 (core load/store) has fixed priority. Master 1 (DMA/debug) is forced
// in after STARVE_LIMIT consecutive M0 grants made while M1 was waiting.
// Each access takes one IDLE grant cycle plus one ACCESS cycle. Completion is a
// registered one-cycle pulse to the winner, one cycle after ACCESS.
//
//   state  | meaning
//   IDLE   | waiting for a request; grants are combinational from the requests
//   ACCESS | latched command drives the memory for exactly one cycle
module dmem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_m0_req,
    input  logic        i_m0_we,
    input  logic [31:0] i_m0_addr,
    input  logic [31:0] i_m0_wdata,
    input  logic [2:0]  i_m0_funct3,
    output logic        o_m0_gnt,
    output logic        o_m0_rvalid,
    output logic [31:0] o_m0_rdata,
    input  logic        i_m1_req,
    input  logic        i_m1_we,
    input  logic [31:0] i_m1_addr,
    input  logic [31:0] i_m1_wdata,
    input  logic [2:0]  i_m1_funct3,
    output logic        o_m1_gnt,
    output logic        o_m1_rvalid,
    output logic [31:0] o_m1_rdata,
    output logic        o_mem_read,
    output logic        o_mem_write,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_dataIn,
    output logic [2:0]  o_mem_funct3,
    input  logic [31:0] i_mem_dataOut
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_ACCESS = 1'b1;

    logic [0:0]    state;
    logic [CW-1:0] starve_cnt;
    logic          force_m1;

    // Latched command of the current winner; cmd_id=1 means master 1.
    logic          cmd_id;
    logic          cmd_we;
    logic [31:0]   cmd_addr;
    logic [31:0]   cmd_wdata;
    logic [2:0]    cmd_funct3;

    assign force_m1 = (starve_cnt == LIMIT);

    // Grant decision: only in IDLE; M0 wins ties unless M1 has been starved.
    always_comb begin
        o_m0_gnt = 1'b0;
        o_m1_gnt = 1'b0;
        if (state == S_IDLE) begin
            if (i_m0_req && (!i_m1_req || !force_m1)) begin
                o_m0_gnt = 1'b1;
            end else if (i_m1_req) begin
                o_m1_gnt = 1'b1;
            end
        end
    end

    // FSM, command latch and starvation counter, all advanced on the grant edge.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= S_IDLE;
            starve_cnt <= '0;
            cmd_id     <= 1'b0;
            cmd_we     <= 1'b0;
            cmd_addr   <= '0;
            cmd_wdata  <= '0;
            cmd_funct3 <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (o_m0_gnt || o_m1_gnt) begin
                        state      <= S_ACCESS;
                        cmd_id     <= o_m1_gnt;
                        cmd_we     <= o_m1_gnt ? i_m1_we     : i_m0_we;
                        cmd_addr   <= o_m1_gnt ? i_m1_addr   : i_m0_addr;
                        cmd_wdata  <= o_m1_gnt ? i_m1_wdata  : i_m0_wdata;
                        cmd_funct3 <= o_m1_gnt ? i_m1_funct3 : i_m0_funct3;
                        if (o_m1_gnt || !i_m1_req) begin
                            starve_cnt <= '0;
                        end else if (!force_m1) begin
                            starve_cnt <= starve_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Memory command is only driven during ACCESS; zero otherwise so a reset
    // mid-access drops read/write immediately.
    always_comb begin
        o_mem_read   = 1'b0;
        o_mem_write  = 1'b0;
        o_mem_addr   = '0;
        o_mem_dataIn = '0;
        o_mem_funct3 = '0;
        if (state == S_ACCESS) begin
            o_mem_read   = !cmd_we;
            o_mem_write  = cmd_we;
            o_mem_addr   = cmd_addr;
            o_mem_dataIn = cmd_wdata;
            o_mem_funct3 = cmd_funct3;
        end
    end

    // Completion: capture read data at the edge ending ACCESS; stores return 0.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_m0_rvalid <= 1'b0;
            o_m1_rvalid <= 1'b0;
            o_m0_rdata  <= '0;
            o_m1_rdata  <= '0;
        end else begin
            o_m0_rvalid <= 1'b0;
            o_m1_rvalid <= 1'b0;
            if (state == S_ACCESS) begin
                if (cmd_id) begin
                    o_m1_rvalid <= 1'b1;
                    o_m1_rdata  <= cmd_we ? 32'd0 : i_mem_dataOut;
                end else begin
                    o_m0_rvalid <= 1'b1;
                    o_m0_rdata  <= cmd_we ? 32'd0 : i_mem_dataOut;
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scenarios plus randomized two-master traffic,
// checked every cycle against a transaction-level reference model.
module tb_dmem_arbiter;

    localparam int LIM = 4;

    logic        clk = 1'b0;
    logic        i_rst;
    logic        i_m0_req = 1'b0, i_m0_we = 1'b0;
    logic [31:0] i_m0_addr = '0, i_m0_wdata = '0;
    logic [2:0]  i_m0_funct3 = '0;
    logic        i_m1_req = 1'b0, i_m1_we = 1'b0;
    logic [31:0] i_m1_addr = '0, i_m1_wdata = '0;
    logic [2:0]  i_m1_funct3 = '0;
    logic        o_m0_gnt, o_m0_rvalid, o_m1_gnt, o_m1_rvalid;
    logic [31:0] o_m0_rdata, o_m1_rdata;
    logic        o_mem_read, o_mem_write;
    logic [31:0] o_mem_addr, o_mem_dataIn, i_mem_dataOut;
    logic [2:0]  o_mem_funct3;

    dmem_arbiter #(.STARVE_LIMIT(LIM)) dut (
        .i_clk(clk), .i_rst(i_rst),
        .i_m0_req(i_m0_req), .i_m0_we(i_m0_we), .i_m0_addr(i_m0_addr),
        .i_m0_wdata(i_m0_wdata), .i_m0_funct3(i_m0_funct3),
        .o_m0_gnt(o_m0_gnt), .o_m0_rvalid(o_m0_rvalid), .o_m0_rdata(o_m0_rdata),
        .i_m1_req(i_m1_req), .i_m1_we(i_m1_we), .i_m1_addr(i_m1_addr),
        .i_m1_wdata(i_m1_wdata), .i_m1_funct3(i_m1_funct3),
        .o_m1_gnt(o_m1_gnt), .o_m1_rvalid(o_m1_rvalid), .o_m1_rdata(o_m1_rdata),
        .o_mem_read(o_mem_read), .o_mem_write(o_mem_write), .o_mem_addr(o_mem_addr),
        .o_mem_dataIn(o_mem_dataIn), .o_mem_funct3(o_mem_funct3),
        .i_mem_dataOut(i_mem_dataOut)
    );

    always #5 clk = ~clk;

    // Memory seen by the DUT: combinational read, write on the rising edge.
    logic [31:0] dmem [0:255];
    logic        pl_en = 1'b0;
    logic [7:0]  pl_idx = '0;
    logic [31:0] pl_data = '0;
    assign i_mem_dataOut = dmem[o_mem_addr[9:2]];

    // Commits DUT stores and bench preloads into the memory array.
    always @(posedge clk) begin
        if (o_mem_write) dmem[o_mem_addr[9:2]] <= o_mem_dataIn;
        else if (pl_en) dmem[pl_idx] <= pl_data;
    end

    int total = 0;
    int bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference model state (transaction level).
    logic [31:0] ref_mem [0:255];
    bit          m_busy = 0;
    int          m_starve = 0;
    bit          c_win = 0, c_we = 0;
    logic [31:0] c_addr = '0, c_wdata = '0;
    logic [2:0]  c_f3 = '0;
    bit          rv0 = 0, rv1 = 0;
    logic [31:0] er0 = '0, er1 = '0;
    int          glog[$];
    int          gcyc[$];
    int          cyc = 0;

    task automatic monitor_step();
        bit eg0, eg1;
        logic [31:0] d;
        int idx;
        cyc++;
        if (pl_en) ref_mem[pl_idx] = pl_data;
        if (i_rst) begin
            check("rst_rvalid0", o_m0_rvalid, 0);
            check("rst_rvalid1", o_m1_rvalid, 0);
            check("rst_mem_read", o_mem_read, 0);
            check("rst_mem_write", o_mem_write, 0);
            check("rst_rdata0", o_m0_rdata, 0);
            check("rst_rdata1", o_m1_rdata, 0);
            m_busy = 0; m_starve = 0; rv0 = 0; rv1 = 0; er0 = '0; er1 = '0;
        end else begin
            eg0 = 0; eg1 = 0;
            if (!m_busy) begin
                if (i_m0_req && i_m1_req) begin
                    if (m_starve == LIM) eg1 = 1; else eg0 = 1;
                end else begin
                    eg0 = i_m0_req; eg1 = i_m1_req;
                end
            end
            check("gnt0", o_m0_gnt, eg0);
            check("gnt1", o_m1_gnt, eg1);
            check("mem_read", o_mem_read, m_busy && !c_we);
            check("mem_write", o_mem_write, m_busy && c_we);
            if (m_busy) begin
                check("mem_addr", o_mem_addr, c_addr);
                check("mem_funct3", o_mem_funct3, c_f3);
                if (c_we) check("mem_dataIn", o_mem_dataIn, c_wdata);
            end
            check("rvalid0", o_m0_rvalid, rv0);
            check("rvalid1", o_m1_rvalid, rv1);
            check("rdata0", o_m0_rdata, er0);
            check("rdata1", o_m1_rdata, er1);
            rv0 = 0; rv1 = 0;
            if (m_busy) begin
                idx = int'(c_addr[9:2]);
                d = c_we ? 32'd0 : ref_mem[idx];
                if (c_we) ref_mem[idx] = c_wdata;
                if (c_win) begin rv1 = 1; er1 = d; end
                else begin rv0 = 1; er0 = d; end
                m_busy = 0;
            end else if (eg0 || eg1) begin
                c_win = eg1;
                c_we = eg1 ? i_m1_we : i_m0_we;
                c_addr = eg1 ? i_m1_addr : i_m0_addr;
                c_wdata = eg1 ? i_m1_wdata : i_m0_wdata;
                c_f3 = eg1 ? i_m1_funct3 : i_m0_funct3;
                if (eg1 || !i_m1_req) m_starve = 0;
                else if (m_starve < LIM) m_starve++;
                glog.push_back(eg1 ? 1 : 0);
                gcyc.push_back(cyc);
                m_busy = 1;
            end
        end
    endtask

    task automatic preload(input logic [31:0] addr, input logic [31:0] data);
        pl_en = 1'b1; pl_idx = addr[9:2]; pl_data = data;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    task automatic set_req(input int m, input logic r);
        if (m == 0) i_m0_req = r; else i_m1_req = r;
    endtask

    // Raise a request and hold it until granted (or optionally withdraw it).
    task automatic issue(input int m, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [2:0] f3, input bit may_drop);
        int n = 0;
        bit done = 0;
        if (m == 0) begin
            i_m0_we = we; i_m0_addr = addr; i_m0_wdata = wdata; i_m0_funct3 = f3;
        end else begin
            i_m1_we = we; i_m1_addr = addr; i_m1_wdata = wdata; i_m1_funct3 = f3;
        end
        set_req(m, 1'b1);
        while (!done) begin
            @(negedge clk);
            if (((m == 0) ? o_m0_gnt : o_m1_gnt) === 1'b1) begin
                @(posedge clk); #1;
                set_req(m, 1'b0);
                done = 1;
            end else begin
                n++;
                @(posedge clk); #1;
                if (n > 200) begin
                    check("gnt_timeout", n, 0);
                    set_req(m, 1'b0);
                    done = 1;
                end else if (may_drop && $urandom_range(0, 7) == 0) begin
                    set_req(m, 1'b0);
                    done = 1;
                end
            end
        end
    endtask

    task automatic wait_grants(input int target);
        int n = 0;
        while (glog.size() < target && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (glog.size() < target) check("grant_timeout", glog.size(), target);
    endtask

    task automatic rand_traffic(input int m, input int count);
        logic [31:0] a;
        for (int k = 0; k < count; k++) begin
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            a = 32'($urandom_range(0, 15)) << 2;
            issue(m, 1'($urandom_range(0, 1)), a, $urandom, 3'($urandom_range(0, 7)), 1);
        end
    endtask

    initial begin
        int base;
        fork
            forever begin
                @(negedge clk);
                monitor_step();
            end
        join_none

        i_rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 256; i++) preload(32'(i) << 2, $urandom);
        i_rst = 1'b0;
        @(posedge clk); #1;

        // Scenario 1: M0 word load.
        preload(32'h10, 32'hDEADBEEF);
        issue(0, 1'b0, 32'h10, 32'h0, 3'b010, 0);
        @(negedge clk);
        check("t1_read", o_mem_read, 1);
        check("t1_addr", o_mem_addr, 32'h10);
        @(negedge clk);
        check("t1_rvalid0", o_m0_rvalid, 1);
        check("t1_rdata0", o_m0_rdata, 32'hDEADBEEF);
        @(posedge clk); #1;

        // Scenario 2: M1 store then load back.
        issue(1, 1'b1, 32'h20, 32'h12345678, 3'b010, 0);
        @(negedge clk);
        check("t2_write_on", o_mem_write, 1);
        @(negedge clk);
        check("t2_write_off", o_mem_write, 0);
        check("t2_rvalid1", o_m1_rvalid, 1);
        check("t2_store_rdata1", o_m1_rdata, 0);
        @(posedge clk); #1;
        issue(1, 1'b0, 32'h20, 32'h0, 3'b010, 0);
        @(negedge clk);
        @(negedge clk);
        check("t2_load_rdata1", o_m1_rdata, 32'h12345678);
        @(posedge clk); #1;

        // Scenario 3: both requesting continuously.
        base = glog.size();
        fork
            repeat (2 * LIM) issue(0, 1'b0, 32'h0, 32'h0, 3'b010, 0);
            repeat (2) issue(1, 1'b0, 32'h4, 32'h0, 3'b010, 0);
        join
        check("t3_count", glog.size() - base, 2 * (LIM + 1));
        for (int i = 0; i < 2 * (LIM + 1) && base + i < glog.size(); i++)
            check($sformatf("t3_seq%0d", i), glog[base + i], (i % (LIM + 1)) == LIM);
        repeat (2) begin @(posedge clk); #1; end

        // Scenario 4: simultaneous requests with an empty starvation count.
        base = glog.size();
        fork
            issue(0, 1'b1, 32'h8, 32'hA5A5_0001, 3'b010, 0);
            issue(1, 1'b0, 32'h8, 32'h0, 3'b010, 0);
        join
        repeat (3) begin @(posedge clk); #1; end
        check("t4_count", glog.size() - base, 2);
        if (glog.size() >= base + 2) begin
            check("t4_first", glog[base], 0);
            check("t4_second", glog[base + 1], 1);
            check("t4_gap", gcyc[base + 1] - gcyc[base], 2);
        end

        // Scenario 5: reset during an M0 store while M1 is waiting.
        preload(32'h40, 32'h1111_2222);
        base = glog.size();
        i_m0_we = 1'b1; i_m0_addr = 32'h40; i_m0_wdata = 32'h5555AAAA; i_m0_funct3 = 3'b010;
        i_m1_we = 1'b0; i_m1_addr = 32'h44; i_m1_wdata = 32'h0; i_m1_funct3 = 3'b010;
        i_m0_req = 1'b1; i_m1_req = 1'b1;
        wait_grants(base + 2);
        i_m0_wdata = 32'hCAFEF00D;
        wait_grants(base + 3);
        for (int i = 0; i < 3 && base + i < glog.size(); i++)
            check($sformatf("t5_pre%0d", i), glog[base + i], 0);
        check("t5_write_before", o_mem_write, 1);
        #2 i_rst = 1'b1;
        #1;
        check("t5_write_drop", o_mem_write, 0);
        check("t5_read_drop", o_mem_read, 0);
        i_m0_req = 1'b0; i_m1_req = 1'b0;
        @(posedge clk); #1;
        i_rst = 1'b0;
        @(negedge clk);
        check("t5_no_rvalid0", o_m0_rvalid, 0);
        @(posedge clk); #1;
        base = glog.size();
        i_m0_we = 1'b0; i_m1_we = 1'b0;
        i_m0_req = 1'b1; i_m1_req = 1'b1;
        wait_grants(base + LIM + 1);
        i_m0_req = 1'b0; i_m1_req = 1'b0;
        for (int i = 0; i <= LIM && base + i < glog.size(); i++)
            check($sformatf("t5_post%0d", i), glog[base + i], i == LIM);
        repeat (2) begin @(posedge clk); #1; end
        issue(0, 1'b0, 32'h40, 32'h0, 3'b010, 0);
        @(negedge clk);
        @(negedge clk);
        check("t5_killed_store", o_m0_rdata, 32'h5555AAAA);
        @(posedge clk); #1;

        // Scenario 6: byte-unsigned load code is passed through.
        preload(32'h30, 32'h0000_00AB);
        issue(1, 1'b0, 32'h30, 32'h0, 3'b100, 0);
        @(negedge clk);
        check("t6_funct3", o_mem_funct3, 3'b100);
        @(negedge clk);
        check("t6_rvalid1", o_m1_rvalid, 1);
        check("t6_rdata1", o_m1_rdata, 32'h0000_00AB);
        @(posedge clk); #1;

        // Randomized concurrent traffic with occasional withdrawn requests.
        fork
            rand_traffic(0, 150);
            rand_traffic(1, 150);
        join
        repeat (4) begin @(posedge clk); #1; end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
